// File: rtl/enigma_step_ctrl.sv
// Enigma keypress sequencer: steps the rotor odometer (with double-step), drives the
// datapath, captures after a settle interval and hands the result out via valid/ready.
// Optional processed-key counter enabled by defining ENIGMA_KEYCOUNT_EN.
module enigma_step_ctrl #(
  parameter int NOTCH1 = 16,
  parameter int NOTCH2 = 4,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [4:0]  key_letter,
  output logic        key_ready,
  input  logic        cfg_load,
  input  logic [4:0]  cfg_pos1,
  input  logic [4:0]  cfg_pos2,
  input  logic [4:0]  cfg_pos3,
  output logic [4:0]  rot1_pos,
  output logic [4:0]  rot2_pos,
  output logic [4:0]  rot3_pos,
  output logic [4:0]  dp_letter,
  input  logic [4:0]  dp_result,
  output logic        out_valid,
  output logic [4:0]  out_letter,
  input  logic        out_ready,
  output logic        err,
  output logic [15:0] key_count
);

  localparam logic [4:0] N1        = 5'(NOTCH1);
  localparam logic [4:0] N2        = 5'(NOTCH2);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, STEP, DRIVE, OUT} state_t;

  state_t     state, state_nxt;
  logic [4:0] letter_q;
  logic [3:0] cnt;
  logic       letter_ok;
  logic       load, accept, capture;

  function automatic logic [4:0] wrap_inc(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] mod26(input logic [4:0] p);
    return (p > 5'd25) ? p - 5'd26 : p;
  endfunction

  assign letter_ok = (letter_q >= 5'd1) && (letter_q <= 5'd26);
  assign key_ready = (state == IDLE) && !cfg_load;
  assign load      = (state == IDLE) && cfg_load;
  assign accept    = key_ready && key_valid;
  assign capture   = (state == DRIVE) && (cnt == SETTLE_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = STEP;
      STEP:  state_nxt = DRIVE;
      DRIVE: if (capture) state_nxt = OUT;
      OUT:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot1_pos   <= '0;
      rot2_pos   <= '0;
      rot3_pos   <= '0;
      letter_q   <= '0;
      dp_letter  <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_letter <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            rot1_pos <= mod26(cfg_pos1);
            rot2_pos <= mod26(cfg_pos2);
            rot3_pos <= mod26(cfg_pos3);
          end else if (accept) begin
            letter_q <= key_letter;
          end
        end
        STEP: begin
          // Notch tests use the pre-step positions; rotor 2 double-steps on its own notch.
          if (letter_ok) begin
            rot1_pos <= wrap_inc(rot1_pos);
            if (rot1_pos == N1 || rot2_pos == N2) rot2_pos <= wrap_inc(rot2_pos);
            if (rot2_pos == N2) rot3_pos <= wrap_inc(rot3_pos);
          end
          dp_letter <= letter_ok ? letter_q : 5'd0;
          cnt       <= '0;
        end
        DRIVE: begin
          cnt <= cnt + 4'd1;
          if (capture) begin
            out_letter <= letter_ok ? dp_result : 5'd0;
            err        <= !letter_ok;
            out_valid  <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            dp_letter <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENIGMA_KEYCOUNT_EN
  logic [15:0] kc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      kc <= '0;
    else if (load)                   kc <= '0;
    else if (capture && letter_ok)   kc <= kc + 16'd1;
  end
  assign key_count = kc;
`else
  assign key_count = 16'd0;
`endif

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed self-checking bench for enigma_step_ctrl; the datapath is a small
// combinational stub so captured letters depend on both letter and positions.
module tb_enigma_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [4:0]  key_letter;
  logic        key_ready;
  logic        cfg_load;
  logic [4:0]  cfg_pos1, cfg_pos2, cfg_pos3;
  logic [4:0]  rot1_pos, rot2_pos, rot3_pos;
  logic [4:0]  dp_letter;
  logic [4:0]  dp_result;
  logic        out_valid;
  logic [4:0]  out_letter;
  logic        out_ready;
  logic        err;
  logic [15:0] key_count;

  int n_checks = 0;
  int n_fails  = 0;
  int kc_exp   = 0;

  always #5 clk = ~clk;

  // Stub datapath: ((letter + pos1 + pos2 + pos3) mod 26) + 1
  assign dp_result = 5'(((int'(dp_letter) + int'(rot1_pos) + int'(rot2_pos)
                         + int'(rot3_pos)) % 26) + 1);

  enigma_step_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_letter(key_letter), .key_ready(key_ready),
    .cfg_load(cfg_load), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2), .cfg_pos3(cfg_pos3),
    .rot1_pos(rot1_pos), .rot2_pos(rot2_pos), .rot3_pos(rot3_pos),
    .dp_letter(dp_letter), .dp_result(dp_result),
    .out_valid(out_valid), .out_letter(out_letter), .out_ready(out_ready),
    .err(err), .key_count(key_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int p1, input int p2, input int p3);
    chk({tag, " rot1"}, int'(rot1_pos), p1);
    chk({tag, " rot2"}, int'(rot2_pos), p2);
    chk({tag, " rot3"}, int'(rot3_pos), p3);
  endtask

  task automatic cfg(input int p1, input int p2, input int p3);
    cfg_pos1 = 5'(p1); cfg_pos2 = 5'(p2); cfg_pos3 = 5'(p3);
    cfg_load = 1'b1;
    #1;
    chk("cfg key_ready", int'(key_ready), 0);
    tick;
    cfg_load = 1'b0;
`ifdef ENIGMA_KEYCOUNT_EN
    kc_exp = 0;
`endif
    chk("cfg key_count", int'(key_count), kc_exp);
  endtask

  // One key through the whole transaction; hold = cycles of backpressure before out_ready.
  task automatic run_key(input string tag, input int l, input int p1, input int p2,
                         input int p3, input int exp_out, input int exp_err, input int hold);
    int n;
    key_letter = 5'(l);
    key_valid  = 1'b1;
    tick;                                   // E0
    key_valid  = 1'b0;
    chk({tag, " key_ready busy"}, int'(key_ready), 0);
    tick;                                   // E1
    chk_pos({tag, " E1"}, p1, p2, p3);
    chk({tag, " dp_letter"}, int'(dp_letter), exp_err ? 0 : l);
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, n, 2);
    chk({tag, " out_letter"}, int'(out_letter), exp_out);
    chk({tag, " err"}, int'(err), exp_err);
`ifdef ENIGMA_KEYCOUNT_EN
    if (exp_err == 0) kc_exp = (kc_exp + 1) & 16'hffff;
`endif
    chk({tag, " key_count"}, int'(key_count), kc_exp);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, " hold valid"}, int'(out_valid), 1);
      chk({tag, " hold letter"}, int'(out_letter), exp_out);
      chk({tag, " hold key_ready"}, int'(key_ready), 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, " retire valid"}, int'(out_valid), 0);
    chk({tag, " retire dp_letter"}, int'(dp_letter), 0);
    chk({tag, " retire key_ready"}, int'(key_ready), 1);
    chk_pos({tag, " retire"}, p1, p2, p3);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_letter = '0; cfg_load = 1'b0;
    cfg_pos1 = '0; cfg_pos2 = '0; cfg_pos3 = '0; out_ready = 1'b0;
    tick; tick;
    chk("reset key_ready", int'(key_ready), 1);
    chk_pos("reset", 0, 0, 0);
    chk("reset dp_letter", int'(dp_letter), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_letter", int'(out_letter), 0);
    chk("reset err", int'(err), 0);
    chk("reset key_count", int'(key_count), 0);
    rst_n = 1'b1;
    tick;

    run_key("basic", 1, 1, 0, 0, 3, 0, 0);

    cfg(16, 0, 0);
    chk_pos("load 16", 16, 0, 0);
    run_key("notch carry", 5, 17, 1, 0, 24, 0, 0);
    cfg(25, 3, 7);
    run_key("wrap", 2, 0, 3, 7, 13, 0, 0);

    cfg(5, 4, 0);
    run_key("dbl a", 3, 6, 5, 1, 16, 0, 0);
    cfg(16, 3, 25);
    run_key("dbl b", 3, 17, 4, 25, 24, 0, 0);
    run_key("dbl c", 3, 18, 5, 0, 1, 0, 0);

    cfg(30, 26, 31);
    chk_pos("load mod26", 4, 0, 5);

    // Load beats a simultaneous key
    cfg_pos1 = 5'd4; cfg_pos2 = 5'd0; cfg_pos3 = 5'd5;
    cfg_load = 1'b1; key_valid = 1'b1; key_letter = 5'd9;
    tick;
    cfg_load = 1'b0; key_valid = 1'b0;
`ifdef ENIGMA_KEYCOUNT_EN
    kc_exp = 0;
`endif
    tick;
    chk("load wins key_ready", int'(key_ready), 1);
    chk_pos("load wins", 4, 0, 5);

    run_key("invalid 0", 0, 4, 0, 5, 0, 1, 0);
    run_key("invalid 27", 27, 4, 0, 5, 0, 1, 0);
    run_key("valid clears err", 1, 5, 0, 5, 12, 0, 0);

    // Backpressure; cfg_load during OUT must be ignored
    cfg_pos1 = 5'd0; cfg_pos2 = 5'd0; cfg_pos3 = 5'd0;
    fork
      begin
        repeat (5) @(posedge clk);
        #2 cfg_load = 1'b1;
        repeat (2) @(posedge clk);
        #2 cfg_load = 1'b0;
      end
    join_none
    run_key("backpressure", 2, 6, 0, 5, 14, 0, 10);

    // Reset while in DRIVE
    key_letter = 5'd1; key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    tick;
    chk("pre-reset dp_letter", int'(dp_letter), 1);
    rst_n = 1'b0;
    #1;
    chk_pos("async reset", 0, 0, 0);
    chk("async reset dp_letter", int'(dp_letter), 0);
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset out_letter", int'(out_letter), 0);
    chk("async reset err", int'(err), 0);
    chk("async reset key_ready", int'(key_ready), 1);
    chk("async reset key_count", int'(key_count), 0);
    kc_exp = 0;
    tick;
    rst_n = 1'b1;
    repeat (4) tick;
    chk("post-reset out_valid", int'(out_valid), 0);
    chk("post-reset key_ready", int'(key_ready), 1);

    run_key("after reset", 4, 1, 0, 0, 6, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/enigma_step_ctrl.md
Name: enigma_step_ctrl

Overview:
- Keypress sequencer for the Enigma datapath (rotors, inverse rotors, reflector).
- Per accepted letter: steps rotor positions (odometer with double-step), drives the letter and the positions into the combinational datapath, waits a settle interval, captures the result, and presents it through a valid/ready handshake.
- Sits between keyboard/button decode and display/UART output logic.

Parameters:
- NOTCH1, 16, rotor-1 (fast) position at which the next key also steps rotor 2 (0..25).
- NOTCH2, 4, rotor-2 position at which the next key double-steps rotor 2 and steps rotor 3 (0..25).
- SETTLE, 2, cycles the datapath input is held before capture; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key_letter valid.
- key_letter  in  5  letter code 1..26 (A=1).
- key_ready  out  1  controller can accept a key.
- cfg_load  in  1  load rotor start positions (honoured in IDLE only).
- cfg_pos1, cfg_pos2, cfg_pos3  in  5 each  start positions 0..25.
- rot1_pos, rot2_pos, rot3_pos  out  5 each  current positions, fed to the datapath rotate inputs.
- dp_letter  out  5  letter driven into the datapath.
- dp_result  in  5  datapath output letter.
- out_valid  out  1  out_letter valid.
- out_letter  out  5  encoded letter (0 = error).
- out_ready  in  1  consumer accepts out_letter.
- err  out  1  last key was invalid.
- key_count  out  16  processed-key count (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; rot*_pos=0; dp_letter=0; out_valid=0; out_letter=0; err=0; key_count=0; settle counter=0. Reset mid-operation aborts the letter; no output is produced.
- key_ready = (state==IDLE) & ~cfg_load. Combinational, registered state only.
- IDLE:
  - cfg_load=1: positions load from cfg_pos*. Values >25 are reduced mod 26 (i.e. minus 26). Stay IDLE.
  - key_valid & key_ready: latch key_letter, go to STEP (acceptance edge E0).
- STEP (edge E1):
  - Valid letter (1..26):
    - rot1 <= rot1+1.
    - rot2 steps if rot1==NOTCH1 or rot2==NOTCH2.
    - rot3 steps if rot2==NOTCH2.
    - All comparisons use pre-step values. All increments wrap 25->0.
  - Invalid letter (0 or 27..31): no stepping; err set on capture.
  - dp_letter <= latched letter (0 if invalid). Counter cleared. Go to DRIVE.
- DRIVE: counter increments each cycle. On the edge where counter reaches SETTLE-1 (edge E1+SETTLE):
  - out_letter <= valid ? dp_result : 0.
  - err <= ~valid.
  - out_valid <= 1; go to OUT.
  - Latency is SETTLE+1 edges from acceptance (3 with the default SETTLE).
- OUT: hold out_letter/out_valid until out_ready=1. On the out_ready edge: out_valid <= 0, dp_letter <= 0, state IDLE.
  - key_ready stays 0 in OUT, so a key cannot be taken on the same edge as output retirement.
- rot*_pos are stable from STEP through OUT; dp_result is sampled only at capture.
- cfg_load outside IDLE is ignored. cfg_load and key_valid together in IDLE: load wins, key not accepted.
- err holds until the next capture.

Optional Feature:
- Macro ENIGMA_KEYCOUNT_EN.
- Defined: key_count increments by 1 on every capture with valid letter, wraps 0xFFFF->0, and is cleared by reset and by cfg_load.
- Undefined: no counter logic; key_count tied to 0.

Test Plan:
- Basic step: reset, key 1 at positions (0,0,0) -> positions (1,0,0) after E1; out_valid rises after E3; out_letter equals dp_result stub; key_ready low until out_ready.
- Notch carry: cfg_load (16,0,0), key 5 -> positions (17,1,0). Then cfg_load (25,3,7), key 2 -> (0,3,7) wrap with no carry.
- Double step: cfg_load (5,4,0), key 3 -> (6,5,1). Then cfg_load (16,3,25), key 3 -> (17,4,25); next key -> (18,5,0).
- Invalid key 0 or 27 -> positions unchanged, out_letter 0, err 1. A following valid key clears err.
- Backpressure plus reset: out_ready held 0 for 10 cycles -> out_valid and out_letter stable, key_ready 0. Assert rst_n=0 in DRIVE -> all outputs 0 immediately, state IDLE.
- With ENIGMA_KEYCOUNT_EN: 3 valid keys plus 1 invalid -> key_count 3; cfg_load -> 0. Without the macro, key_count stays 0.
